// File: rtl/throw_trajectory_cat_if.sv
// Player-input / projectile-draw signal bundle for throw_trajectory_cat.
// master = turn/input logic side, slave = trajectory generator.
interface throw_trajectory_cat_if;
    logic        vsync;
    logic        throw_btn;
    logic        throw_en;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        enable;
    logic [7:0]  power;
    logic        busy;
    logic        landed;

    modport master (
        output vsync, throw_btn, throw_en,
        input  x_pos, y_pos, enable, power, busy, landed
    );

    modport slave (
        input  vsync, throw_btn, throw_en,
        output x_pos, y_pos, enable, power, busy, landed
    );
endinterface

// File: rtl/throw_trajectory_cat.sv
// Cat projectile trajectory: charge power while the button is held, launch at 45 deg
// on release, integrate one step per frame (vsync rising edge) and detect landing.
module throw_trajectory_cat #(
    parameter int unsigned START_X   = 100,
    parameter int unsigned START_Y   = 150,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned MIN_POWER = 4,
    parameter int unsigned MAX_POWER = 24,
    parameter int unsigned X_MAX     = 1024
) (
    input logic                   clk,
    input logic                   rst,
    throw_trajectory_cat_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHARGE,
        S_FLIGHT,
        S_LANDED
    } state_e;

    localparam logic [11:0]        START_X12 = 12'(START_X);
    localparam logic [11:0]        START_Y12 = 12'(START_Y);
    localparam logic [11:0]        X_MAX12   = 12'(X_MAX);
    localparam logic signed [13:0] START_YS  = 14'(START_Y);
    localparam logic signed [13:0] X_MAXS    = 14'(X_MAX);
    localparam logic signed [13:0] Y_LIMS    = 14'sd4095;

    state_e            state_q, state_d;
    logic              vsync_q;
    logic [11:0]       x_q, x_d;
    logic [11:0]       y_q, y_d;
    logic [7:0]        vx_q, vx_d;
    logic signed [8:0] vy_q, vy_d;
    logic [7:0]        power_q, power_d;
    logic              landed_q, landed_d;

    logic              tick;
    logic signed [13:0] x_n;
    logic signed [13:0] y_n;

    // Height can exceed the 12-bit output range at high power; pin it rather than wrap.
    function automatic logic [11:0] sat_y(input logic signed [13:0] v);
        logic [11:0] r;
        if (v > Y_LIMS) r = 12'hFFF;
        else            r = v[11:0];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vsync_q  <= 1'b0;
            x_q      <= START_X12;
            y_q      <= START_Y12;
            vx_q     <= '0;
            vy_q     <= '0;
            power_q  <= '0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vsync_q  <= bus.vsync;
            x_q      <= x_d;
            y_q      <= y_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            power_q  <= power_d;
            landed_q <= landed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        power_d  = power_q;
        landed_d = 1'b0;

        tick = bus.vsync & ~vsync_q;
        x_n  = $signed({2'b00, x_q}) + $signed({6'b000000, vx_q});
        y_n  = $signed({2'b00, y_q}) + $signed({{5{vy_q[8]}}, vy_q});

        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.throw_btn && bus.throw_en) begin
                        state_d = S_CHARGE;
                        power_d = 8'(MIN_POWER);
                    end
                end
                S_CHARGE: begin
                    if (bus.throw_btn) begin
                        if (power_q < 8'(MAX_POWER)) power_d = power_q + 8'd1;
                    end else begin
                        state_d = S_FLIGHT;
                        vx_d    = power_q;
                        vy_d    = $signed({1'b0, power_q});
                    end
                end
                S_FLIGHT: begin
                    vy_d = vy_q - 9'(GRAVITY);
                    // Wall hit wins over ground hit when both occur on the same frame.
                    if (x_n >= X_MAXS) begin
                        state_d = S_LANDED;
                        x_d     = X_MAX12;
                        y_d     = (y_n < START_YS) ? START_Y12 : sat_y(y_n);
                    end else if (y_n <= START_YS) begin
                        state_d = S_LANDED;
                        x_d     = x_n[11:0];
                        y_d     = START_Y12;
                    end else begin
                        x_d = x_n[11:0];
                        y_d = sat_y(y_n);
                    end
                end
                S_LANDED: begin
                    state_d  = S_IDLE;
                    landed_d = 1'b1;
                    x_d      = START_X12;
                    y_d      = START_Y12;
                    vx_d     = '0;
                    vy_d     = '0;
                    power_d  = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.x_pos  = x_q;
        bus.y_pos  = y_q;
        bus.enable = (state_q == S_FLIGHT) || (state_q == S_LANDED);
        bus.power  = power_q;
        bus.busy   = (state_q != S_IDLE);
        bus.landed = landed_q;
    end

endmodule

// File: tb/tb_throw_trajectory_cat.sv
// Scoreboard bench for throw_trajectory_cat: a frame-level reference model pushes expected
// outputs per frame tick / reset cycle; a monitor pops and compares after each update.
module tb_throw_trajectory_cat;

    localparam int SX = 100;
    localparam int SY = 150;
    localparam int G  = 1;
    localparam int PMIN = 4;
    localparam int PMAX = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vsync = 1'b0;
    logic btn = 1'b0;
    logic en = 1'b0;

    always #5 clk = ~clk;

    throw_trajectory_cat_if bus0 ();
    throw_trajectory_cat_if bus1 ();

    assign bus0.vsync = vsync;
    assign bus0.throw_btn = btn;
    assign bus0.throw_en = en;
    assign bus1.vsync = vsync;
    assign bus1.throw_btn = btn;
    assign bus1.throw_en = en;

    throw_trajectory_cat #(.X_MAX(1024)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    throw_trajectory_cat #(.X_MAX(150))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic [11:0] ax[2];
    logic [11:0] ay[2];
    logic [7:0]  apw[2];
    logic        aen[2];
    logic        abusy[2];
    logic        ald[2];

    assign ax[0] = bus0.x_pos;   assign ax[1] = bus1.x_pos;
    assign ay[0] = bus0.y_pos;   assign ay[1] = bus1.y_pos;
    assign apw[0] = bus0.power;  assign apw[1] = bus1.power;
    assign aen[0] = bus0.enable; assign aen[1] = bus1.enable;
    assign abusy[0] = bus0.busy; assign abusy[1] = bus1.busy;
    assign ald[0] = bus0.landed; assign ald[1] = bus1.landed;

    typedef struct {
        int x;
        int y;
        int en;
        int pw;
        int busy;
        int ld;
    } exp_t;

    exp_t sbq[2][$];

    // Model phases: 0 waiting, 1 charging, 2 in the air, 3 on the ground for one frame
    int ph[2];
    int px[2];
    int py[2];
    int mvx[2];
    int mvy[2];
    int pw[2];
    int xlim[2] = '{1024, 150};

    int checks = 0;
    int passes = 0;

    function automatic exp_t snap(input int k, input int ld);
        exp_t e;
        e.x = px[k];
        e.y = py[k];
        e.en = (ph[k] >= 2) ? 1 : 0;
        e.pw = pw[k];
        e.busy = (ph[k] != 0) ? 1 : 0;
        e.ld = ld;
        return e;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; px[k] = SX; py[k] = SY; mvx[k] = 0; mvy[k] = 0; pw[k] = 0;
            sbq[k].push_back(snap(k, 0));
        end
    endfunction

    function automatic void model_tick(input int b, input int e);
        int nx, ny, ld;
        for (int k = 0; k < 2; k++) begin
            ld = 0;
            if (ph[k] == 0) begin
                if (b != 0 && e != 0) begin ph[k] = 1; pw[k] = PMIN; end
            end else if (ph[k] == 1) begin
                if (b != 0) pw[k] = (pw[k] + 1 > PMAX) ? PMAX : pw[k] + 1;
                else begin ph[k] = 2; mvx[k] = pw[k]; mvy[k] = pw[k]; end
            end else if (ph[k] == 2) begin
                nx = px[k] + mvx[k];
                ny = py[k] + mvy[k];
                mvy[k] = mvy[k] - G;
                if (nx >= xlim[k]) begin
                    px[k] = xlim[k]; py[k] = (ny < SY) ? SY : ny; ph[k] = 3;
                end else if (ny <= SY) begin
                    px[k] = nx; py[k] = SY; ph[k] = 3;
                end else begin
                    px[k] = nx; py[k] = ny;
                end
            end else begin
                ph[k] = 0; px[k] = SX; py[k] = SY; pw[k] = 0; mvx[k] = 0; mvy[k] = 0;
                ld = 1;
            end
            sbq[k].push_back(snap(k, ld));
        end
    endfunction

    task automatic chk(input int k, input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL dut%0d %s: got %0d expected %0d at %0t", k, nm, act, exp, $time);
    endtask

    // Monitor: an output update follows every reset cycle and every vsync rising edge.
    logic prev_vs = 1'b0;
    logic ev = 1'b0;
    logic ldchk = 1'b0;

    always @(posedge clk) begin
        ev <= rst || (vsync && !prev_vs);
        prev_vs <= rst ? 1'b0 : vsync;
    end

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (ev) begin
                if (sbq[k].size() == 0) begin
                    chk(k, "unexpected_update", 1, 0);
                end else begin
                    e = sbq[k].pop_front();
                    chk(k, "x_pos", int'(ax[k]), e.x);
                    chk(k, "y_pos", int'(ay[k]), e.y);
                    chk(k, "enable", int'(aen[k]), e.en);
                    chk(k, "power", int'(apw[k]), e.pw);
                    chk(k, "busy", int'(abusy[k]), e.busy);
                    chk(k, "landed", int'(ald[k]), e.ld);
                end
            end else if (ldchk) begin
                chk(k, "landed_width", int'(ald[k]), 0);
            end
        end
        ldchk <= ev;
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            vsync = 1'b0;
            model_reset();
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame(input int b, input int e, input int hi, input int lo);
        @(negedge clk);
        btn = b[0];
        en = e[0];
        vsync = 1'b1;
        model_tick(b, e);
        @(negedge clk);
        btn = 1'($urandom_range(0, 1));
        en = 1'($urandom_range(0, 1));
        repeat (hi - 1) @(negedge clk);
        vsync = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic rframe(input int b, input int e);
        frame(b, e, int'($urandom_range(1, 8)), int'($urandom_range(1, 4)));
    endtask

    initial begin
        do_reset(2);

        // Turn gating: button alone never starts a charge
        repeat (3) rframe(1, 0);

        // Basic throw at power 6, one long vsync pulse, throw_en wandering in flight
        repeat (3) rframe(1, 1);
        frame(0, 1, 40, 2);
        repeat (14) rframe(0, int'($urandom_range(0, 1)));

        // Held button after landing only recharges once throw_en is back
        rframe(1, 0);
        rframe(1, 1);
        rframe(0, 1);
        repeat (4) rframe(0, 1);
        do_reset(1);

        // Saturation and the x wall (second instance has a near wall)
        repeat (30) rframe(1, 1);
        rframe(0, 1);
        repeat (60) rframe(0, int'($urandom_range(0, 1)));

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            rframe(int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0);
        end

        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) chk(k, "queue_drained", sbq[k].size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
